// File: rtl/ram16x8_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ram16x8_pkg
//  Description : Shared geometry constants for the 16 x 8 program/run RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram16x8_pkg;

    // Address width: 4 bits selects one of 16 words.
    localparam int ADDR_W = 4;

    // Word width in bits.
    localparam int DATA_W = 8;

    // Number of words. Equals 2**ADDR_W, so every address is valid
    // and no range check is needed on the index.
    localparam int DEPTH  = 16;

endpackage : ram16x8_pkg
`default_nettype wire

// File: rtl/ram16x8.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : ram16x8
//  Description : 16-word x 8-bit register-file RAM with programming and run
//                modes. Writes happen on the rising clock edge. Reads are
//                combinational. The output is forced to zero when the chip is
//                not enabled, so several of these can be OR-combined onto a
//                shared bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram16x8
    import ram16x8_pkg::*;
(
    output logic [DATA_W-1:0] out,
    input  logic              clk,
    input  logic              clr,
    input  logic              write,
    input  logic              prog,
    input  logic              ce,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d
);

    // Storage array: one register per word.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Qualified write strobe.
    logic w_we;

    // Write enable: programming mode ignores ce, run mode requires ce.
    // A change on prog simply alters this qualifier, so the new mode takes
    // effect on the next edge without any transition state.
    always_comb begin
        w_we = write & (prog | ce);
    end

    // Clear has priority over a write. The address and data are only used
    // when a write is enabled, so junk values on them cannot disturb memory.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[a] <= d;
        end
    end

    // Asynchronous read with zero-forcing when the chip is deselected. There
    // is no write bypass: during a write the old word is visible until the
    // edge.
    always_comb begin
        out = '0;
        if (ce) begin
            out = r_mem[a];
        end
    end

endmodule : ram16x8
`default_nettype wire

// File: tb/tb_ram16x8.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ram16x8
//  Description : Directed self-checking bench for ram16x8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16x8;

    logic       clk;
    logic       clr;
    logic       write;
    logic       prog;
    logic       ce;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] out;

    int checks = 0;
    int errors = 0;

    ram16x8 u_dut (
        .out   (out),
        .clk   (clk),
        .clr   (clr),
        .write (write),
        .prog  (prog),
        .ce    (ce),
        .a     (a),
        .d     (d)
    );

    // Clock generator with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move away from it before anything else.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; write = 1'b0; prog = 1'b0; ce = 1'b0; a = '0; d = '0;
        #2;

        // Reset: clear every word, then sweep all addresses.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ce  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("reset_a%0d", i), out, 8'h00);
        end

        // Programming mode with ce low: writes land and the output stays 0.
        prog = 1'b1; ce = 1'b0; write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            d = 8'(i + 1);
            #1;
            check($sformatf("prog_ce0_a%0d", i), out, 8'h00);
            tick();
        end
        write = 1'b0; ce = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("prog_read_a%0d", i), out, 8'(i + 1));
        end

        // Run mode gating: with ce low no write happens, with ce high it does.
        prog = 1'b0; write = 1'b1; ce = 1'b0; a = 4'd3; d = 8'hAA;
        tick();
        write = 1'b0; ce = 1'b1;
        #1;
        check("run_ce0_nowrite", out, 8'h04);
        write = 1'b1;
        tick();
        write = 1'b0;
        #1;
        check("run_ce1_write", out, 8'hAA);
        a = 4'd2;
        #1;
        check("run_neighbor", out, 8'h03);

        // Read during write: old word before the edge, new word after it.
        a = 4'd5; d = 8'h11; write = 1'b1;
        tick();
        d = 8'h22;
        #1;
        check("rdw_before", out, 8'h11);
        tick();
        write = 1'b0;
        #1;
        check("rdw_after", out, 8'h22);

        // Clear takes priority over a simultaneous programming write.
        clr = 1'b1; write = 1'b1; prog = 1'b1; a = 4'd7; d = 8'hFF;
        tick();
        clr = 1'b0; write = 1'b0; prog = 1'b0; ce = 1'b1;
        #1;
        check("clr_priority_a7", out, 8'h00);
        a = 4'd5;
        #1;
        check("clr_all_a5", out, 8'h00);

        // Load a distinct pattern for the hold test.
        prog = 1'b1; write = 1'b1; ce = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            d = 8'(i) ^ 8'h5A;
            tick();
        end
        write = 1'b0; prog = 1'b0;

        // Hold: toggle address and data with write low for 32 cycles.
        for (int i = 0; i < 32; i++) begin
            a  = 4'(i * 7);
            d  = (i % 2 == 0) ? 8'hFF : 8'h00;
            ce = 1'(i % 2);
            prog = 1'((i / 2) % 2);
            #1;
            if (i % 2 == 0) begin
                check($sformatf("hold_ce0_%0d", i), out, 8'h00);
            end
            tick();
        end
        ce = 1'b1; prog = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            check($sformatf("hold_a%0d", i), out, 8'(i) ^ 8'h5A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram16x8
`default_nettype wire

// File: doc/ram16x8.md
RAM16X8 -- requirements
Module: ram16x8

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port clr, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port write, input, 1 bit: write request.
REQ-004 The block SHALL have the port prog, input, 1 bit: 1 = programming mode, 0 = run mode.
REQ-005 The block SHALL have the port ce, input, 1 bit: chip enable, active-high; gates output drive and run-mode writes.
REQ-006 The block SHALL have the port a, input, 4 bits: word address 0..15.
REQ-007 The block SHALL have the port d, input, 8 bits: write data.
REQ-008 The block SHALL have the port out, output, 8 bits: read data.
REQ-009 Port order SHALL be out, clk, clr, write, prog, ce, a, d.

Function
REQ-010 Storage SHALL be 16 words x 8 bits, indexed directly by a; no address wrap logic is needed beyond the 4-bit width.
REQ-011 Read SHALL be combinational: out = mem[a] whenever ce=1, with zero clock latency.
REQ-012 out SHALL be 8'h00 whenever ce=0 (no tri-state; the bus is OR-combined upstream).
REQ-013 In programming mode (prog=1), a rising clk with write=1 SHALL store d into mem[a], independent of ce.
REQ-014 In run mode (prog=0), a rising clk SHALL store d into mem[a] only when write=1 and ce=1.
REQ-015 With write=0, memory contents SHALL be unchanged on every edge.
REQ-016 Read-during-write to the same address SHALL show the old word before the edge and the new word immediately after it (no bypass).
REQ-017 A prog change SHALL take effect on the next rising edge; no mode transition state exists.
REQ-018 X/Z on a or d while no write is enabled SHALL NOT corrupt memory.

Reset
REQ-019 On a rising clk with clr=1, all 16 words SHALL be cleared to 8'h00.
REQ-020 clr SHALL have priority over any simultaneous write on the same edge.
REQ-021 After reset with ce=1, out SHALL read 8'h00 at every address.
REQ-022 Before the first reset, memory contents are undefined and SHALL NOT be relied on.

Structure
REQ-023 A shared package SHALL define ADDR_W=4, DATA_W=8 and DEPTH=16; the module SHALL use these constants only.
REQ-024 The module SHALL be a single flat module with no sub-modules: a register array, one clocked write/reset process, and combinational read/output gating.

Verification
REQ-025 Reset test: clr=1 for one edge, then ce=1 with a swept 0..15 -> out=8'h00 at every address.
REQ-026 Program test: prog=1, ce=0, write=1, d=a+1 for a=0..15 -> each write lands; out=0 while ce=0; then ce=1, write=0 -> out=a+1 at every address.
REQ-027 Run-mode gating test: prog=0, write=1, ce=0, a=3, d=8'hAA -> mem[3] unchanged; then ce=1 -> mem[3]=8'hAA on the next edge.
REQ-028 Read-during-write test: mem[5]=8'h11; write 8'h22 at a=5 -> out=8'h11 before the edge and 8'h22 after it.
REQ-029 Reset priority test: clr=1, write=1, prog=1, a=7, d=8'hFF on the same edge -> mem[7]=8'h00.
REQ-030 Hold test: write=0 while a and d toggle every cycle for 32 cycles -> all contents unchanged.
